// File: rtl/sb_pattern_detect.sv
// Sideband clock-pattern detector for SBINIT: pulses done after REQ_MATCHES consecutive pattern words, or flags a timeout.
// Optional macro SB_PATTERN_DETECT_PHASE_TOL_EN also accepts the one-UI-slipped pattern (~PATTERN).
module sb_pattern_detect #(
    parameter int                 DATA_W         = 64,
    parameter logic [DATA_W-1:0]  PATTERN        = 64'hAAAA_AAAA_AAAA_AAAA,
    parameter int                 REQ_MATCHES    = 2,
    parameter int                 TIMEOUT_CYCLES = 800
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_detect_en,
    input  logic [DATA_W-1:0]                  i_deser_data,
    input  logic                               i_deser_valid,
    output logic                               o_rx_sb_pattern_samp_done,
    output logic                               o_detect_time_out,
    output logic [$clog2(REQ_MATCHES+1)-1:0]   o_match_cnt,
    output logic                               o_busy
);

    localparam int CNT_W = $clog2(REQ_MATCHES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [1:0] ST_TOUT   = 2'd3;

    logic [1:0]       state_r, state_nxt_s;
    logic [CNT_W-1:0] match_cnt_r, cnt_nxt_s, run_cnt_s, cnt_inc_s;
    logic [TMO_W-1:0] tmo_cnt_r, tmo_nxt_s;
    logic             done_r, done_nxt_s;
    logic             tout_r, tout_nxt_s;
    logic             busy_r;
    logic             hit_s;

    // Saturating increment keeps the run count bounded at REQ_MATCHES.
    assign cnt_inc_s = (match_cnt_r == CNT_W'(REQ_MATCHES)) ? match_cnt_r
                                                             : match_cnt_r + CNT_W'(1);

`ifdef SB_PATTERN_DETECT_PHASE_TOL_EN
    logic phase_r, phase_nxt_s, inv_s;

    // Run-length update with phase tracking: a phase flip restarts the run at one.
    always_comb begin
        inv_s     = (i_deser_data == ~PATTERN);
        hit_s     = (i_deser_data == PATTERN) || inv_s;
        run_cnt_s = match_cnt_r;
        if (!i_deser_valid) begin
            run_cnt_s = match_cnt_r;
        end else if (!hit_s) begin
            run_cnt_s = CNT_W'(0);
        end else if ((match_cnt_r != CNT_W'(0)) && (inv_s != phase_r)) begin
            run_cnt_s = CNT_W'(1);
        end else begin
            run_cnt_s = cnt_inc_s;
        end
    end

    // Phase of the current run; cleared whenever the detector is idle.
    always_comb begin
        phase_nxt_s = phase_r;
        if (state_r != ST_SEARCH) begin
            phase_nxt_s = 1'b0;
        end else if (i_deser_valid && hit_s) begin
            phase_nxt_s = inv_s;
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Phase-tracking flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_r <= 1'b0;
        end else begin
            phase_r <= phase_nxt_s;
        end
    end
`else
    // Run-length update for an exact pattern match; idle cycles keep the count.
    always_comb begin
        hit_s     = (i_deser_data == PATTERN);
        run_cnt_s = match_cnt_r;
        if (!i_deser_valid) begin
            run_cnt_s = match_cnt_r;
        end else if (hit_s) begin
            run_cnt_s = cnt_inc_s;
        end else begin
            run_cnt_s = CNT_W'(0);
        end
    end
`endif

    // Next-state logic; a final match takes priority over timeout expiry.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = match_cnt_r;
        tmo_nxt_s   = tmo_cnt_r;
        done_nxt_s  = 1'b0;
        tout_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = CNT_W'(0);
                tmo_nxt_s = TMO_W'(0);
                if (i_detect_en) begin
                    state_nxt_s = ST_SEARCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (!i_detect_en) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_W'(0);
                    tmo_nxt_s   = TMO_W'(0);
                end else begin
                    cnt_nxt_s = run_cnt_s;
                    if (i_deser_valid && hit_s && (run_cnt_s == CNT_W'(REQ_MATCHES))) begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                        tmo_nxt_s   = TMO_W'(0);
                    end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt_s = ST_TOUT;
                        tout_nxt_s  = 1'b1;
                        tmo_nxt_s   = TMO_W'(0);
                    end else begin
                        tmo_nxt_s = tmo_cnt_r + TMO_W'(1);
                    end
                end
            end
            ST_DONE, ST_TOUT: begin
                if (!i_detect_en) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_W'(0);
                    tmo_nxt_s   = TMO_W'(0);
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_W'(0);
                tmo_nxt_s   = TMO_W'(0);
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            match_cnt_r <= CNT_W'(0);
            tmo_cnt_r   <= TMO_W'(0);
            done_r      <= 1'b0;
            tout_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            match_cnt_r <= cnt_nxt_s;
            tmo_cnt_r   <= tmo_nxt_s;
            done_r      <= done_nxt_s;
            tout_r      <= tout_nxt_s;
            busy_r      <= (state_nxt_s == ST_SEARCH);
        end
    end

    assign o_rx_sb_pattern_samp_done = done_r;
    assign o_detect_time_out         = tout_r;
    assign o_match_cnt               = match_cnt_r;
    assign o_busy                    = busy_r;

endmodule

// File: tb/tb_sb_pattern_detect.sv
// Directed plus randomized bench for sb_pattern_detect against a cycle-level behavioural model.
module tb_sb_pattern_detect;

    localparam logic [63:0] PAT  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] NPAT = 64'h5555_5555_5555_5555;
    localparam logic [63:0] JUNK = 64'h1234_5678_9ABC_DEF0;
    localparam int          REQ  = 2;
    localparam int          TMO  = 800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        valid;
    logic [63:0] data;
    logic        samp_done;
    logic        time_out;
    logic [1:0]  match_cnt;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    // Model: searching/finished flags, length of the current run, cycles spent searching.
    bit m_search;
    bit m_fin;
    bit m_phase;
    int m_run;
    int m_elapsed;
    bit m_done;
    bit m_tout;

    sb_pattern_detect dut (
        .i_clk                     (clk),
        .i_rst_n                   (rst_n),
        .i_detect_en               (en),
        .i_deser_data              (data),
        .i_deser_valid             (valid),
        .o_rx_sb_pattern_samp_done (samp_done),
        .o_detect_time_out         (time_out),
        .o_match_cnt               (match_cnt),
        .o_busy                    (busy)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_search  = 1'b0;
        m_fin     = 1'b0;
        m_phase   = 1'b0;
        m_run     = 0;
        m_elapsed = 0;
        m_done    = 1'b0;
        m_tout    = 1'b0;
    endtask

    task automatic model_word(input logic [63:0] d);
`ifdef SB_PATTERN_DETECT_PHASE_TOL_EN
        bit ph;
        if (d == PAT || d == NPAT) begin
            ph = (d == NPAT);
            if (m_run > 0 && ph != m_phase) m_run = 1;
            else if (m_run < REQ) m_run = m_run + 1;
            m_phase = ph;
        end else begin
            m_run = 0;
        end
`else
        if (d == PAT) begin
            if (m_run < REQ) m_run = m_run + 1;
        end else begin
            m_run = 0;
        end
`endif
    endtask

    task automatic model_edge(input bit e, input bit v, input logic [63:0] d);
        m_done = 1'b0;
        m_tout = 1'b0;
        if (!e) begin
            model_clear();
        end else if (m_search) begin
            m_elapsed = m_elapsed + 1;
            if (v) model_word(d);
            if (v && m_run == REQ) begin
                m_done   = 1'b1;
                m_search = 1'b0;
                m_fin    = 1'b1;
            end else if (m_elapsed == TMO) begin
                m_tout   = 1'b1;
                m_search = 1'b0;
                m_fin    = 1'b1;
            end
        end else if (!m_fin) begin
            m_search  = 1'b1;
            m_elapsed = 0;
            m_run     = 0;
        end
    endtask

    task automatic check(input string tag);
        logic [1:0] exp_cnt;
        exp_cnt = 2'(m_run);
        vectors++;
        assert (samp_done === m_done) else begin
            miscompares++;
            $error("FAIL %s samp_done observed=%0b expected=%0b", tag, samp_done, m_done);
        end
        vectors++;
        assert (time_out === m_tout) else begin
            miscompares++;
            $error("FAIL %s time_out observed=%0b expected=%0b", tag, time_out, m_tout);
        end
        vectors++;
        assert (match_cnt === exp_cnt) else begin
            miscompares++;
            $error("FAIL %s match_cnt observed=%0d expected=%0d", tag, match_cnt, exp_cnt);
        end
        vectors++;
        assert (busy === m_search) else begin
            miscompares++;
            $error("FAIL %s busy observed=%0b expected=%0b", tag, busy, m_search);
        end
    endtask

    task automatic step(input bit e, input bit v, input logic [63:0] d, input string tag);
        @(negedge clk);
        en    = e;
        valid = v;
        data  = d;
        @(posedge clk);
        model_edge(e, v, d);
        #1;
        check(tag);
    endtask

    initial begin
        int r;
        rst_n = 1'b0;
        en    = 1'b0;
        valid = 1'b0;
        data  = 64'd0;
        model_clear();
        #12;
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic detection on back-to-back words, then hold in DONE.
        step(1'b0, 1'b0, 64'd0, "idle");
        step(1'b1, 1'b0, 64'd0, "enter");
        step(1'b1, 1'b1, PAT,   "m1");
        step(1'b1, 1'b1, PAT,   "m2_pulse");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, PAT, "done_hold");
        step(1'b0, 1'b0, 64'd0, "drop");

        // Mismatch breaks the run: counts 1,0,1,2.
        step(1'b1, 1'b0, 64'd0, "enter2");
        step(1'b1, 1'b1, PAT,   "seq_a");
        step(1'b1, 1'b1, JUNK,  "seq_junk");
        step(1'b1, 1'b1, PAT,   "seq_b");
        step(1'b1, 1'b1, PAT,   "seq_c");
        step(1'b1, 1'b0, 64'd0, "seq_hold");
        step(1'b0, 1'b0, 64'd0, "drop2");

        // Invalid gaps keep the run.
        step(1'b1, 1'b0, 64'd0, "enter3");
        step(1'b1, 1'b1, PAT,   "gap_m1");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, PAT ^ 64'd1, "gap");
        step(1'b1, 1'b1, PAT,   "gap_m2");
        step(1'b0, 1'b0, 64'd0, "drop3");

        // Slipped pattern words.
        step(1'b1, 1'b0, 64'd0, "enter4");
        step(1'b1, 1'b1, NPAT,  "npat1");
        step(1'b1, 1'b1, NPAT,  "npat2");
        step(1'b1, 1'b1, PAT,   "npat_pat");
        step(1'b1, 1'b1, PAT,   "npat_pat2");
        step(1'b0, 1'b0, 64'd0, "drop4");

        // Timeout window, then re-arm for a second full window.
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 64'd0, "tmo_enter");
            for (int i = 0; i < TMO + 3; i++) step(1'b1, 1'b0, 64'd0, "tmo_win");
            step(1'b0, 1'b0, 64'd0, "tmo_drop");
        end

        // Final match on the last cycle of the window: done wins.
        step(1'b1, 1'b0, 64'd0, "race_enter");
        step(1'b1, 1'b1, PAT,   "race_m1");
        for (int i = 0; i < TMO - 2; i++) step(1'b1, 1'b0, 64'd0, "race_wait");
        step(1'b1, 1'b1, PAT,   "race_final");
        vectors++;
        assert (samp_done === 1'b1 && time_out === 1'b0) else begin
            miscompares++;
            $error("FAIL race done/tout observed=%0b/%0b expected=1/0", samp_done, time_out);
        end
        step(1'b1, 1'b0, 64'd0, "race_after");
        step(1'b0, 1'b0, 64'd0, "drop5");

        // Asynchronous reset mid-search with one match counted.
        step(1'b1, 1'b0, 64'd0, "rst_enter");
        step(1'b1, 1'b1, PAT,   "rst_m1");
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 64'd0, "post_rst");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] d;
            r = int'($urandom_range(0, 9));
            if (r < 5)       d = PAT;
            else if (r == 5) d = NPAT;
            else             d = {$urandom, $urandom};
            step($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)), d, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sb_pattern_detect.md
Name: sb_pattern_detect

Overview:
- Receive-side companion of the sideband pattern generator in the SBINIT flow.
- Monitors 64-bit words from the sideband deserializer for the clock pattern 0xAAAA_AAAA_AAAA_AAAA.
- Pulses o_rx_sb_pattern_samp_done once REQ_MATCHES consecutive matching words arrive; the generator consumes this pulse to start its final four iterations.
- Also flags a detection timeout to the LTSM.

Parameters:
- DATA_W, 64, deserialized word width.
- PATTERN, 64'hAAAA_AAAA_AAAA_AAAA, expected clock pattern word ({32{2'b10}}).
- REQ_MATCHES, 2, consecutive valid matching words needed for detection (>=1).
- TIMEOUT_CYCLES, 800, i_clk cycles in SEARCH before timeout (8 ms at 100 cycles/ms).

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_detect_en  input  1  level enable from LTSM; low forces IDLE
- i_deser_data  input  DATA_W  deserialized sideband word
- i_deser_valid  input  1  i_deser_data valid this cycle
- o_rx_sb_pattern_samp_done  output  1  one-cycle pulse: pattern detected
- o_detect_time_out  output  1  one-cycle pulse: timeout expired
- o_match_cnt  output  $clog2(REQ_MATCHES+1)  current consecutive match count
- o_busy  output  1  high while in SEARCH

Behaviour:
- Reset is i_rst_n, asynchronous, active-low; clock is i_clk.
- All outputs reset to 0. All counters reset to 0. State resets to IDLE.
- All outputs are registered.
- State machine has four states: IDLE, SEARCH, DONE, TOUT.
- IDLE:
  - Counters held at 0.
  - i_detect_en=1 -> SEARCH next cycle.
- SEARCH:
  - o_busy=1.
  - Timeout counter increments every cycle.
  - On i_deser_valid with data==PATTERN: match_cnt+1.
  - On i_deser_valid with data!=PATTERN: match_cnt=0.
  - Cycles with i_deser_valid=0 leave match_cnt unchanged; gaps do not break consecutiveness.
  - When a valid match would make match_cnt==REQ_MATCHES:
    - o_rx_sb_pattern_samp_done=1 on the next cycle, for exactly one cycle.
    - -> DONE.
  - Latency: last matching word at cycle N -> pulse at N+1.
  - When the timeout counter reaches TIMEOUT_CYCLES-1:
    - o_detect_time_out=1 on the next cycle, for one cycle.
    - -> TOUT.
    - Timeout counter cleared.
- DONE and TOUT:
  - Hold; no further pulses.
  - o_match_cnt frozen at its final value.
  - Return to IDLE only when i_detect_en=0.
- i_detect_en=0 in any state:
  - -> IDLE next cycle.
  - Counters cleared.
  - No pulse generated.
- Simultaneous final match and timeout expiry in the same cycle: the match wins. Done pulses, timeout does not; -> DONE.
- Re-arm: after IDLE, a fresh i_detect_en rise restarts detection from match_cnt=0 with a full timeout window.
- Mid-operation reset: asynchronous return to IDLE; all outputs 0 immediately.
- match_cnt saturates at REQ_MATCHES; the timeout counter never wraps.

Optional Feature:
- Macro: SB_PATTERN_DETECT_PHASE_TOL_EN.
- Defined:
  - A valid word also matches if it equals ~PATTERN (0x5555_5555_5555_5555), covering a one-UI phase slip.
  - All words in one consecutive run must use the same phase: a phase change counts as a mismatch and sets match_cnt=1 with the new phase.
  - A phase-tracking flop is added.
- Not defined: only an exact PATTERN counts; no phase flop is present.

Test Plan:
- Reset, i_detect_en=1, two valid 0xAAAA.. words on consecutive cycles 5,6 -> samp_done pulse at cycle 7 for one cycle; o_match_cnt=2; state DONE; no timeout.
- Sequence AAAA.., 1234_5678_9ABC_DEF0, AAAA.., AAAA.. (all valid) -> match_cnt goes 1,0,1,2; single pulse after the fourth word.
- Two matching words separated by 5 cycles of i_deser_valid=0 -> detection still pulses; match_cnt stays 1 during the gap.
- i_detect_en=1 with no valid data for 800 cycles -> o_detect_time_out pulses once at cycle 801 after SEARCH entry; drop en -> IDLE; re-raise -> new 800-cycle window.
- Final match on the same cycle as timeout expiry -> samp_done=1 and o_detect_time_out=0; i_rst_n asserted mid-SEARCH with match_cnt=1 -> all outputs 0 immediately.
- With SB_PATTERN_DETECT_PHASE_TOL_EN defined:
  - 0x5555.. twice -> pulse.
  - 0x5555.. then 0xAAAA.. -> match_cnt=1, no pulse.
  - Without the macro, 0x5555.. never matches.
